// File: rtl/pwm_pkg.sv
// Shared mode encodings and default sizing for the N-channel PWM timer.
// Purely declarative; no logic, no latency, no flow control.
package pwm_pkg;

    typedef enum logic {
        PWM_MODE_PC   = 1'b0,
        PWM_MODE_FAST = 1'b1
    } pwm_mode_e;

    localparam int PWM_WIDTH_DEF     = 32;
    localparam int PWM_N_CH_DEF      = 4;
    localparam int PWM_DT_CYCLES_DEF = 8;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter, compiled only with PWM_DEADTIME_EN.
// Latency: rising edges delayed DT_CYCLES, falling edges immediate; no backpressure.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime #(
    parameter int DT_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pwm_p,
    output logic pwm_n
);

    localparam int              CW     = $clog2(DT_CYCLES + 1);
    localparam logic [CW-1:0]   DT_MAX = CW'(DT_CYCLES);

    logic          raw_q, raw_d;
    logic [CW-1:0] stable_q, stable_d;
    logic          p_q, p_d, n_q, n_d;

    // stable_d counts cycles raw has held its level, including the current one
    always_comb begin
        raw_d = raw;
        if (raw != raw_q) begin
            stable_d = CW'(1);
        end else if (stable_q < DT_MAX) begin
            stable_d = stable_q + CW'(1);
        end else begin
            stable_d = stable_q;
        end
        p_d = raw && (stable_d >= DT_MAX);
        n_d = !raw && (stable_d >= DT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q    <= 1'b0;
            stable_q <= '0;
            p_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            raw_q    <= raw_d;
            stable_q <= stable_d;
            p_q      <= p_d;
            n_q      <= n_d;
        end
    end

    // Gating with the live raw level makes both falls immediate and overlap impossible
    assign pwm_p = p_q && raw;
    assign pwm_n = n_q && !raw;

endmodule
`endif

// File: rtl/pwm_phase_correct_nch.sv
// N-channel PWM timer: shared up/up-down counter, per-channel compare, double-buffered config.
// Latency: pwm_out 1 cycle after cnt; config applies at the period boundary; cfg_ready low while an update is pending.
// Optional dead-time / complementary outputs with PWM_DEADTIME_EN.
module pwm_phase_correct_nch
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH_DEF,
    parameter int N_CH      = PWM_N_CH_DEF,
    parameter int DT_CYCLES = PWM_DT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_mode,
    input  logic [WIDTH-1:0]       cfg_top,
    input  logic [N_CH*WIDTH-1:0]  cfg_cmp,
    output logic [WIDTH-1:0]       cnt,
    output logic                   dir_down,
    output logic                   period_tick,
    output logic                   update_ack,
    output logic [N_CH-1:0]        pwm_out
`ifdef PWM_DEADTIME_EN
    ,
    output logic [N_CH-1:0]        pwm_out_n
`endif
);

    if (WIDTH < 1 || N_CH < 1 || DT_CYCLES < 1) begin : g_param_check
        $error("pwm_phase_correct_nch: WIDTH, N_CH and DT_CYCLES must all be >= 1");
    end

    logic [WIDTH-1:0]      cnt_q, cnt_d, cnt_nx;
    logic                  dir_q, dir_d, dir_nx;
    logic [WIDTH-1:0]      top_q, top_d, sh_top_q, sh_top_d;
    logic [N_CH*WIDTH-1:0] cmp_q, cmp_d, sh_cmp_q, sh_cmp_d;
    pwm_mode_e             mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic                  pend_q, pend_d;
    logic                  ack_q, ack_d;
    logic [N_CH-1:0]       raw_q, raw_d;
    logic                  term, accept, apply;

    always_comb begin
        term   = 1'b0;
        cnt_nx = cnt_q;
        dir_nx = dir_q;
        if (top_q == '0) begin
            term = 1'b1;
        end else if (mode_q == PWM_MODE_FAST) begin
            if (cnt_q >= top_q) begin
                term = 1'b1;
            end else begin
                cnt_nx = cnt_q + WIDTH'(1);
            end
        end else begin
            if (!dir_q && cnt_q < top_q) begin
                cnt_nx = cnt_q + WIDTH'(1);
            end else begin
                cnt_nx = cnt_q - WIDTH'(1);
                dir_nx = 1'b1;
            end
            // Reaching zero on the way down (top==1 included) closes the period
            if (cnt_nx == '0) begin
                term = 1'b1;
            end
        end

        // accept and apply are mutually exclusive through pend_q
        accept = cfg_valid && !pend_q;
        apply  = enable && term && pend_q;

        cnt_d     = cnt_q;
        dir_d     = dir_q;
        raw_d     = raw_q;
        top_d     = top_q;
        cmp_d     = cmp_q;
        mode_d    = mode_q;
        sh_top_d  = sh_top_q;
        sh_cmp_d  = sh_cmp_q;
        sh_mode_d = sh_mode_q;
        pend_d    = pend_q;
        ack_d     = apply;

        if (enable) begin
            if (term) begin
                cnt_d = '0;
                dir_d = 1'b0;
            end else begin
                cnt_d = cnt_nx;
                dir_d = dir_nx;
            end
            for (int i = 0; i < N_CH; i++) begin
                raw_d[i] = cnt_q < cmp_q[i*WIDTH +: WIDTH];
            end
        end

        if (apply) begin
            top_d  = sh_top_q;
            cmp_d  = sh_cmp_q;
            mode_d = sh_mode_q;
            pend_d = 1'b0;
        end

        if (accept) begin
            sh_top_d  = cfg_top;
            sh_cmp_d  = cfg_cmp;
            sh_mode_d = pwm_mode_e'(cfg_mode);
            pend_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            top_q     <= '0;
            cmp_q     <= '0;
            mode_q    <= PWM_MODE_PC;
            sh_top_q  <= '0;
            sh_cmp_q  <= '0;
            sh_mode_q <= PWM_MODE_PC;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            raw_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            top_q     <= top_d;
            cmp_q     <= cmp_d;
            mode_q    <= mode_d;
            sh_top_q  <= sh_top_d;
            sh_cmp_q  <= sh_cmp_d;
            sh_mode_q <= sh_mode_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            raw_q     <= raw_d;
        end
    end

    assign cnt         = cnt_q;
    assign dir_down    = dir_q;
    assign cfg_ready   = !pend_q;
    assign period_tick = enable && term;
    assign update_ack  = ack_q;

`ifdef PWM_DEADTIME_EN
    for (genvar g = 0; g < N_CH; g++) begin : g_dt
        pwm_deadtime #(
            .DT_CYCLES (DT_CYCLES)
        ) u_dt (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_q[g]),
            .pwm_p (pwm_out[g]),
            .pwm_n (pwm_out_n[g])
        );
    end
`else
    assign pwm_out = raw_q;
`endif

endmodule

// File: tb/tb_pwm_phase_correct_nch.sv
// Directed bench for pwm_phase_correct_nch (default build, WIDTH=32, N_CH=4).
module tb_pwm_phase_correct_nch;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic           cfg_valid;
    logic           cfg_ready;
    logic           cfg_mode;
    logic [W-1:0]   cfg_top;
    logic [N*W-1:0] cfg_cmp;
    logic [W-1:0]   cnt;
    logic           dir_down;
    logic           period_tick;
    logic           update_ack;
    logic [N-1:0]   pwm_out;
`ifdef PWM_DEADTIME_EN
    logic [N-1:0]   pwm_out_n;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int highs;
    int pc4 [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    pwm_phase_correct_nch dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_top     (cfg_top),
        .cfg_cmp     (cfg_cmp),
        .cnt         (cnt),
        .dir_down    (dir_down),
        .period_tick (period_tick),
        .update_ack  (update_ack),
        .pwm_out     (pwm_out)
`ifdef PWM_DEADTIME_EN
        ,
        .pwm_out_n   (pwm_out_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic mode, input logic [W-1:0] top,
                         input logic [W-1:0] c0, input logic [W-1:0] c1,
                         input logic [W-1:0] c2, input logic [W-1:0] c3);
        cfg_valid = 1'b1;
        cfg_mode  = mode;
        cfg_top   = top;
        cfg_cmp   = {c3, c2, c1, c0};
    endtask

`ifdef PWM_DEADTIME_EN
    always @(negedge clk) begin
        if (!reset) chk("dt_overlap", 64'(pwm_out & pwm_out_n), 64'd0);
    end
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
        cfg_mode = 1'b0; cfg_top = '0; cfg_cmp = '0;
        tick(); tick();
        chk("rst_cnt",   64'(cnt), 64'd0);
        chk("rst_dir",   64'(dir_down), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_pwm",   64'(pwm_out), 64'd0);
        chk("rst_ack",   64'(update_ack), 64'd0);
        chk("rst_tick",  64'(period_tick), 64'd0);

        // Phase-correct, top=4, cmp0=2; active top=0 so every cycle is terminal
        reset = 1'b0; enable = 1'b1;
        offer(1'b0, 4, 2, 0, 0, 0);
        #1 chk("top0_tick", 64'(period_tick), 64'd1);
        tick();
        chk("t1_ready_low", 64'(cfg_ready), 64'd0);
        chk("t1_no_same_edge_ack", 64'(update_ack), 64'd0);
        cfg_valid = 1'b0;
        tick();
        chk("t1_ack", 64'(update_ack), 64'd1);
        chk("t1_ready_back", 64'(cfg_ready), 64'd1);
        highs = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) tick();
            chk("t1_cnt", 64'(cnt), 64'(pc4[i % 8]));
            chk("t1_dir", 64'(dir_down), 64'((i % 8) > 4));
            chk("t1_tick", 64'(period_tick), 64'((i % 8) == 7));
            if (i == 1) chk("t1_ack_one_cycle", 64'(update_ack), 64'd0);
            if (i > 0 && pwm_out[0]) highs++;
        end
        // cnt<2 occurs at 0,1 (up) and 1 (down): 3 of 8 cycles
        chk("t1_duty", 64'(highs), 64'd3);

        // Mid-period compare change 2 -> 3 at cnt=2
        tick(); tick();
        chk("t3_cnt2", 64'(cnt), 64'd2);
        offer(1'b0, 4, 3, 0, 0, 0);
        tick();
        chk("t3_ready_low", 64'(cfg_ready), 64'd0);
        cfg_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t3_cnt1", 64'(cnt), 64'd1);
        chk("t3_old_duty", 64'(pwm_out[0]), 64'd0);
        chk("t3_term", 64'(period_tick), 64'd1);
        chk("t3_still_pending", 64'(cfg_ready), 64'd0);
        tick();
        chk("t3_ack", 64'(update_ack), 64'd1);
        chk("t3_cnt0", 64'(cnt), 64'd0);
        tick(); tick(); tick();
        chk("t3_new_duty", 64'(pwm_out[0]), 64'd1);
        chk("t3_cnt3", 64'(cnt), 64'd3);

        // Switch to fast while counting down at cnt=3
        tick();
        chk("t4_cnt4", 64'(cnt), 64'd4);
        tick();
        chk("t4_down3", 64'(dir_down), 64'd1);
        offer(1'b1, 4, 2, 0, 5, 0);
        tick();
        chk("t4_still_pc_cnt", 64'(cnt), 64'd2);
        chk("t4_still_pc_dir", 64'(dir_down), 64'd1);
        cfg_valid = 1'b0;
        tick();
        chk("t4_cnt1_tick", 64'(period_tick), 64'd1);
        tick();
        chk("t4_ack", 64'(update_ack), 64'd1);
        chk("t4_cnt0", 64'(cnt), 64'd0);
        chk("t4_dir0", 64'(dir_down), 64'd0);
        chk("t4_pwm_old", 64'(pwm_out), 64'b0001);

        // Fast top=4: ch0 cmp2, ch1 cmp0 (never), ch2 cmp5 > top (always)
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_cnt", 64'(cnt), 64'((i + 1) % 5));
            chk("t2_dir", 64'(dir_down), 64'd0);
            chk("t2_tick", 64'(period_tick), 64'(((i + 1) % 5) == 4));
            chk("t2_pwm", 64'(pwm_out), 64'({1'b0, 1'b1, 1'b0, (i % 5) < 2}));
            if (i == 0) chk("t2_ack_one_pulse", 64'(update_ack), 64'd0);
            if (i < 5 && pwm_out[0]) highs++;
        end
        chk("t2_duty", 64'(highs), 64'd2);

        // top=0, cmp0=1
        offer(1'b1, 0, 1, 0, 0, 0);
        tick();
        cfg_valid = 1'b0;
        chk("t5_cnt1", 64'(cnt), 64'd1);
        tick(); tick(); tick(); tick();
        chk("t5_ack", 64'(update_ack), 64'd1);
        chk("t5_cnt0", 64'(cnt), 64'd0);
        chk("t5_tick", 64'(period_tick), 64'd1);
        chk("t5_pwm_old", 64'(pwm_out), 64'b0100);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t5_hold_cnt", 64'(cnt), 64'd0);
            chk("t5_every_tick", 64'(period_tick), 64'd1);
            chk("t5_pwm", 64'(pwm_out), 64'b0001);
        end

        // Freeze: handshake still accepts, nothing else moves
        enable = 1'b0;
        offer(1'b0, 8, 4, 0, 0, 0);
        #1 chk("frz_tick0", 64'(period_tick), 64'd0);
        tick();
        chk("frz_accept", 64'(cfg_ready), 64'd0);
        chk("frz_pwm", 64'(pwm_out), 64'b0001);
        cfg_valid = 1'b0;
        tick();
        chk("frz_no_ack", 64'(update_ack), 64'd0);
        enable = 1'b1;
        #1 chk("unfrz_tick", 64'(period_tick), 64'd1);
        tick();
        chk("unfrz_ack", 64'(update_ack), 64'd1);
        tick(); tick(); tick();
        chk("pc8_cnt3", 64'(cnt), 64'd3);
        enable = 1'b0;
        tick(); tick();
        chk("frz_cnt", 64'(cnt), 64'd3);
        chk("frz_dir", 64'(dir_down), 64'd0);
        chk("frz_pwm2", 64'(pwm_out), 64'b0001);
        chk("frz_tick", 64'(period_tick), 64'd0);
        enable = 1'b1;
        tick();
        chk("resume_cnt4", 64'(cnt), 64'd4);

        // Reset with a pending update: shadow must be discarded
        offer(1'b1, 2, 1, 1, 1, 1);
        tick();
        chk("t6_pending", 64'(cfg_ready), 64'd0);
        cfg_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("t6_cnt", 64'(cnt), 64'd0);
        chk("t6_ready", 64'(cfg_ready), 64'd1);
        chk("t6_pwm", 64'(pwm_out), 64'd0);
        chk("t6_dir", 64'(dir_down), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_ack", 64'(update_ack), 64'd0);
            chk("t6_cnt_hold", 64'(cnt), 64'd0);
            chk("t6_top0_tick", 64'(period_tick), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
